// File: rtl/ma_request_ctrl_pkg.sv
// Shared CPU definitions for the memory-access request controller:
// FSM states, access size encoding and the alignment rule.
package ma_request_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_REQ   = 2'b01,
      ST_WAIT  = 2'b10,
      ST_DRAIN = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
   function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lsb);
      logic mis;
      mis = 1'b0;
      if (size == SIZE_HALF) begin
         mis = addr_lsb[0];
      end else if (size == SIZE_WORD) begin
         mis = (addr_lsb != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/ma_request_ctrl_if.sv
// EX-side request, memory-side request/response and load-result bundle
// for ma_request_ctrl; slave is the controller, master is its environment.
interface ma_request_ctrl_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned STRB_W = XLEN / 8;

   logic              i_req_valid;
   logic              o_req_ready;
   logic              i_req_we;
   logic [XLEN-1:0]   i_req_addr;
   logic [XLEN-1:0]   i_req_wdata;
   logic [STRB_W-1:0] i_req_wstrb;
   logic [1:0]        i_req_size;
   logic              i_req_unsigned;
   logic              i_flush;

   logic              o_mem_req_valid;
   logic              i_mem_req_ready;
   logic [XLEN-1:0]   o_mem_addr;
   logic              o_mem_we;
   logic [XLEN-1:0]   o_mem_wdata;
   logic [STRB_W-1:0] o_mem_wstrb;
   logic              i_mem_rsp_valid;
   logic [XLEN-1:0]   i_mem_rsp_data;

   logic              o_ld_valid;
   logic [XLEN-1:0]   o_ld_addr;
   logic [XLEN-1:0]   o_ld_rdata;
   logic [1:0]        o_ld_size;
   logic              o_ld_unsigned;
   logic              o_misaligned;

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wstrb,
             i_req_size, i_req_unsigned, i_flush,
             i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
      output o_req_ready, o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wdata,
             o_mem_wstrb, o_ld_valid, o_ld_addr, o_ld_rdata, o_ld_size,
             o_ld_unsigned, o_misaligned
   );

   modport master (
      output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wstrb,
             i_req_size, i_req_unsigned, i_flush,
             i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
      input  o_req_ready, o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wdata,
             o_mem_wstrb, o_ld_valid, o_ld_addr, o_ld_rdata, o_ld_size,
             o_ld_unsigned, o_misaligned
   );

endinterface

// File: rtl/ma_request_ctrl.sv
// Memory-access request controller: accepts one EX-side load/store at a time,
// issues a word-aligned memory request and hands raw load data to load_unit.
module ma_request_ctrl
   import ma_request_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic             i_clk,
   input logic             i_rst_n,
   ma_request_ctrl_if.slave bus
);

   localparam int unsigned STRB_W = XLEN / 8;

   state_e            state_q,         state_n;
   logic              req_ready_q,     req_ready_n;
   logic              mem_req_valid_q, mem_req_valid_n;
   logic [XLEN-1:0]   mem_addr_q,      mem_addr_n;
   logic              mem_we_q,        mem_we_n;
   logic [XLEN-1:0]   mem_wdata_q,     mem_wdata_n;
   logic [STRB_W-1:0] mem_wstrb_q,     mem_wstrb_n;
   logic [XLEN-1:0]   lat_addr_q,      lat_addr_n;
   size_e             lat_size_q,      lat_size_n;
   logic              lat_unsigned_q,  lat_unsigned_n;
   logic              ld_valid_q,      ld_valid_n;
   logic [XLEN-1:0]   ld_addr_q,       ld_addr_n;
   logic [XLEN-1:0]   ld_rdata_q,      ld_rdata_n;
   logic [1:0]        ld_size_q,       ld_size_n;
   logic              ld_unsigned_q,   ld_unsigned_n;
   logic              misaligned_q,    misaligned_n;

   // Next-state and next-output logic; flush always takes priority over progress.
   always_comb begin
      state_n        = state_q;
      mem_addr_n     = mem_addr_q;
      mem_we_n       = mem_we_q;
      mem_wdata_n    = mem_wdata_q;
      mem_wstrb_n    = mem_wstrb_q;
      lat_addr_n     = lat_addr_q;
      lat_size_n     = lat_size_q;
      lat_unsigned_n = lat_unsigned_q;
      ld_valid_n     = 1'b0;
      ld_addr_n      = ld_addr_q;
      ld_rdata_n     = ld_rdata_q;
      ld_size_n      = ld_size_q;
      ld_unsigned_n  = ld_unsigned_q;
      misaligned_n   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_req_valid && !bus.i_flush) begin
               if (is_misaligned(size_e'(bus.i_req_size), bus.i_req_addr[1:0])) begin
                  misaligned_n = 1'b1;
               end else begin
                  state_n        = ST_REQ;
                  mem_addr_n     = {bus.i_req_addr[XLEN-1:2], 2'b00};
                  mem_we_n       = bus.i_req_we;
                  mem_wdata_n    = bus.i_req_wdata;
                  mem_wstrb_n    = bus.i_req_wstrb;
                  lat_addr_n     = bus.i_req_addr;
                  lat_size_n     = size_e'(bus.i_req_size);
                  lat_unsigned_n = bus.i_req_unsigned;
               end
            end
         end
         ST_REQ: begin
            if (bus.i_flush) begin
               state_n = ST_IDLE;
            end else if (bus.i_mem_req_ready) begin
               state_n = mem_we_q ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.i_mem_rsp_valid) begin
               state_n = ST_IDLE;
               if (!bus.i_flush) begin
                  ld_valid_n    = 1'b1;
                  ld_addr_n     = lat_addr_q;
                  ld_rdata_n    = bus.i_mem_rsp_data;
                  ld_size_n     = lat_size_q;
                  ld_unsigned_n = lat_unsigned_q;
               end
            end else if (bus.i_flush) begin
               state_n = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.i_mem_rsp_valid) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      mem_req_valid_n = (state_n == ST_REQ);
      req_ready_n     = (state_n == ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q         <= ST_IDLE;
         req_ready_q     <= 1'b1;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         mem_we_q        <= 1'b0;
         mem_wdata_q     <= '0;
         mem_wstrb_q     <= '0;
         lat_addr_q      <= '0;
         lat_size_q      <= SIZE_BYTE;
         lat_unsigned_q  <= 1'b0;
         ld_valid_q      <= 1'b0;
         ld_addr_q       <= '0;
         ld_rdata_q      <= '0;
         ld_size_q       <= 2'b00;
         ld_unsigned_q   <= 1'b0;
         misaligned_q    <= 1'b0;
      end else begin
         state_q         <= state_n;
         req_ready_q     <= req_ready_n;
         mem_req_valid_q <= mem_req_valid_n;
         mem_addr_q      <= mem_addr_n;
         mem_we_q        <= mem_we_n;
         mem_wdata_q     <= mem_wdata_n;
         mem_wstrb_q     <= mem_wstrb_n;
         lat_addr_q      <= lat_addr_n;
         lat_size_q      <= lat_size_n;
         lat_unsigned_q  <= lat_unsigned_n;
         ld_valid_q      <= ld_valid_n;
         ld_addr_q       <= ld_addr_n;
         ld_rdata_q      <= ld_rdata_n;
         ld_size_q       <= ld_size_n;
         ld_unsigned_q   <= ld_unsigned_n;
         misaligned_q    <= misaligned_n;
      end
   end

   assign bus.o_req_ready     = req_ready_q;
   assign bus.o_mem_req_valid = mem_req_valid_q;
   assign bus.o_mem_addr      = mem_addr_q;
   assign bus.o_mem_we        = mem_we_q;
   assign bus.o_mem_wdata     = mem_wdata_q;
   assign bus.o_mem_wstrb     = mem_wstrb_q;
   assign bus.o_ld_valid      = ld_valid_q;
   assign bus.o_ld_addr       = ld_addr_q;
   assign bus.o_ld_rdata      = ld_rdata_q;
   assign bus.o_ld_size       = ld_size_q;
   assign bus.o_ld_unsigned   = ld_unsigned_q;
   assign bus.o_misaligned    = misaligned_q;

endmodule

// File: tb/tb_ma_request_ctrl.sv
// Directed bench for ma_request_ctrl: loads, stores with backpressure,
// misalignment, flushes in every busy state and reset mid-access.
module tb_ma_request_ctrl;

   logic i_clk;
   logic i_rst_n;
   int   checks;
   int   errors;

   ma_request_ctrl_if #(.XLEN(32)) bus ();

   ma_request_ctrl #(.XLEN(32)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one cycle; outputs are then stable for sampling and inputs may change.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [1:0] size, input logic uns);
      bus.i_req_valid    = 1'b1;
      bus.i_req_we       = we;
      bus.i_req_addr     = addr;
      bus.i_req_wdata    = wdata;
      bus.i_req_wstrb    = wstrb;
      bus.i_req_size     = size;
      bus.i_req_unsigned = uns;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      i_rst_n             = 1'b0;
      bus.i_req_valid     = 1'b0;
      bus.i_req_we        = 1'b0;
      bus.i_req_addr      = '0;
      bus.i_req_wdata     = '0;
      bus.i_req_wstrb     = '0;
      bus.i_req_size      = 2'b00;
      bus.i_req_unsigned  = 1'b0;
      bus.i_flush         = 1'b0;
      bus.i_mem_req_ready = 1'b0;
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rsp_data  = '0;

      repeat (2) step();
      i_rst_n = 1'b1;
      step();
      check("rst_ready",     32'(bus.o_req_ready), 32'd1);
      check("rst_memvalid",  32'(bus.o_mem_req_valid), 32'd0);
      check("rst_ldvalid",   32'(bus.o_ld_valid), 32'd0);
      check("rst_misalign",  32'(bus.o_misaligned), 32'd0);
      check("rst_memaddr",   bus.o_mem_addr, 32'h0);
      check("rst_ldrdata",   bus.o_ld_rdata, 32'h0);

      // LW 0x104, memory ready immediately, response at N+2
      bus.i_mem_req_ready = 1'b1;
      drive_req(1'b0, 32'h104, 32'h0, 4'h0, 2'b10, 1'b0);
      step();
      bus.i_req_valid = 1'b0;
      check("lw_n1_memvalid", 32'(bus.o_mem_req_valid), 32'd1);
      check("lw_n1_memaddr",  bus.o_mem_addr, 32'h104);
      check("lw_n1_memwe",    32'(bus.o_mem_we), 32'd0);
      check("lw_n1_ready",    32'(bus.o_req_ready), 32'd0);
      step();
      check("lw_n2_memvalid", 32'(bus.o_mem_req_valid), 32'd0);
      check("lw_n2_ldvalid",  32'(bus.o_ld_valid), 32'd0);
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rsp_data  = 32'hDEADBEEF;
      step();
      bus.i_mem_rsp_valid = 1'b0;
      check("lw_n3_ldvalid",  32'(bus.o_ld_valid), 32'd1);
      check("lw_n3_rdata",    bus.o_ld_rdata, 32'hDEADBEEF);
      check("lw_n3_ldaddr",   bus.o_ld_addr, 32'h104);
      check("lw_n3_ldsize",   32'(bus.o_ld_size), 32'd2);
      check("lw_n3_ready",    32'(bus.o_req_ready), 32'd1);
      step();
      check("lw_n4_ldvalid",  32'(bus.o_ld_valid), 32'd0);
      check("lw_n4_hold",     bus.o_ld_rdata, 32'hDEADBEEF);

      // SH 0x202 with memory backpressure for 3 cycles
      bus.i_mem_req_ready = 1'b0;
      drive_req(1'b1, 32'h202, 32'hABCD0000, 4'hC, 2'b01, 1'b0);
      step();
      bus.i_req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sh_c%0d_memvalid", i), 32'(bus.o_mem_req_valid), 32'd1);
         check($sformatf("sh_c%0d_memaddr", i),  bus.o_mem_addr, 32'h200);
         check($sformatf("sh_c%0d_ldvalid", i),  32'(bus.o_ld_valid), 32'd0);
         if (i == 3) bus.i_mem_req_ready = 1'b1;
         step();
      end
      bus.i_mem_req_ready = 1'b0;
      check("sh_memwe",      32'(bus.o_mem_we), 32'd1);
      check("sh_wstrb",      32'(bus.o_mem_wstrb), 32'hC);
      check("sh_wdata",      bus.o_mem_wdata, 32'hABCD0000);
      check("sh_done_valid", 32'(bus.o_mem_req_valid), 32'd0);
      check("sh_done_ready", 32'(bus.o_req_ready), 32'd1);
      check("sh_done_ld",    32'(bus.o_ld_valid), 32'd0);
      step();
      check("sh_idle_ld",    32'(bus.o_ld_valid), 32'd0);

      // LH 0x101 is misaligned
      drive_req(1'b0, 32'h101, 32'h0, 4'h0, 2'b01, 1'b0);
      step();
      bus.i_req_valid = 1'b0;
      check("lh_mis_pulse",  32'(bus.o_misaligned), 32'd1);
      check("lh_mis_mem",    32'(bus.o_mem_req_valid), 32'd0);
      check("lh_mis_ready",  32'(bus.o_req_ready), 32'd1);
      step();
      check("lh_mis_end",    32'(bus.o_misaligned), 32'd0);
      check("lh_mis_mem2",   32'(bus.o_mem_req_valid), 32'd0);

      // LB 0x103, flush in WAIT, response two cycles later is discarded
      bus.i_mem_req_ready = 1'b1;
      drive_req(1'b0, 32'h103, 32'h0, 4'h0, 2'b00, 1'b1);
      step();
      bus.i_req_valid = 1'b0;
      check("lb_memaddr",    bus.o_mem_addr, 32'h100);
      step();
      bus.i_flush = 1'b1;
      step();
      bus.i_flush = 1'b0;
      check("lb_drain_ready", 32'(bus.o_req_ready), 32'd0);
      step();
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rsp_data  = 32'h11223344;
      step();
      bus.i_mem_rsp_valid = 1'b0;
      check("lb_flush_ld",    32'(bus.o_ld_valid), 32'd0);
      check("lb_flush_ready", 32'(bus.o_req_ready), 32'd1);
      check("lb_flush_hold",  bus.o_ld_rdata, 32'hDEADBEEF);

      // Flush in IDLE ignores a concurrent request
      drive_req(1'b0, 32'h300, 32'h0, 4'h0, 2'b10, 1'b0);
      bus.i_flush = 1'b1;
      step();
      bus.i_req_valid = 1'b0;
      bus.i_flush     = 1'b0;
      check("fidle_mem",   32'(bus.o_mem_req_valid), 32'd0);
      check("fidle_ready", 32'(bus.o_req_ready), 32'd1);

      // Flush in REQ wins over same-cycle memory ready
      drive_req(1'b0, 32'h304, 32'h0, 4'h0, 2'b10, 1'b0);
      bus.i_mem_req_ready = 1'b0;
      step();
      bus.i_req_valid     = 1'b0;
      bus.i_flush         = 1'b1;
      bus.i_mem_req_ready = 1'b1;
      step();
      bus.i_flush = 1'b0;
      check("freq_mem",   32'(bus.o_mem_req_valid), 32'd0);
      check("freq_ready", 32'(bus.o_req_ready), 32'd1);

      // LHU 0x106 completes with unsigned flag and halfword size
      drive_req(1'b0, 32'h106, 32'h0, 4'h0, 2'b01, 1'b1);
      step();
      bus.i_req_valid = 1'b0;
      step();
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rsp_data  = 32'h5A5A1234;
      step();
      bus.i_mem_rsp_valid = 1'b0;
      check("lhu_ldvalid", 32'(bus.o_ld_valid), 32'd1);
      check("lhu_ldaddr",  bus.o_ld_addr, 32'h106);
      check("lhu_size",    32'(bus.o_ld_size), 32'd1);
      check("lhu_uns",     32'(bus.o_ld_unsigned), 32'd1);

      // Flush coincident with the response discards it
      drive_req(1'b0, 32'h10C, 32'h0, 4'h0, 2'b10, 1'b0);
      step();
      bus.i_req_valid = 1'b0;
      step();
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rsp_data  = 32'h0BADF00D;
      bus.i_flush         = 1'b1;
      step();
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_flush         = 1'b0;
      check("fcoin_ld",    32'(bus.o_ld_valid), 32'd0);
      check("fcoin_ready", 32'(bus.o_req_ready), 32'd1);
      check("fcoin_hold",  bus.o_ld_rdata, 32'h5A5A1234);

      // Reset during WAIT, late response ignored
      drive_req(1'b0, 32'h108, 32'h0, 4'h0, 2'b10, 1'b0);
      step();
      bus.i_req_valid = 1'b0;
      step();
      i_rst_n = 1'b0;
      #1;
      check("rstw_ldrdata", bus.o_ld_rdata, 32'h0);
      check("rstw_ldaddr",  bus.o_ld_addr, 32'h0);
      check("rstw_memaddr", bus.o_mem_addr, 32'h0);
      check("rstw_memval",  32'(bus.o_mem_req_valid), 32'd0);
      check("rstw_ldvalid", 32'(bus.o_ld_valid), 32'd0);
      step();
      i_rst_n             = 1'b1;
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rsp_data  = 32'hCAFEF00D;
      step();
      bus.i_mem_rsp_valid = 1'b0;
      check("rstw_late_ld",    32'(bus.o_ld_valid), 32'd0);
      check("rstw_late_rdata", bus.o_ld_rdata, 32'h0);
      check("rstw_late_ready", 32'(bus.o_req_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ma_request_ctrl.md
MA_REQUEST_CTRL -- requirements
Module: ma_request_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have port i_clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_req_valid  input  1  EX-side access request valid.
REQ-005 SHALL have port o_req_ready  output  1  block can accept request.
REQ-006 SHALL have port i_req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port i_req_addr  input  XLEN  byte address.
REQ-008 SHALL have port i_req_wdata  input  XLEN  lane-positioned store data.
REQ-009 SHALL have port i_req_wstrb  input  XLEN/8  store byte strobes.
REQ-010 SHALL have port i_req_size  input  2  00 byte, 01 halfword, 10 word.
REQ-011 SHALL have port i_req_unsigned  input  1  LBU/LHU.
REQ-012 SHALL have port i_flush  input  1  pipeline flush.
REQ-013 SHALL have port o_mem_req_valid  output  1  memory request valid.
REQ-014 SHALL have port i_mem_req_ready  input  1  memory accepts request.
REQ-015 SHALL have port o_mem_addr  output  XLEN  word-aligned address (bits[1:0]=0).
REQ-016 SHALL have port o_mem_we  output  1  memory write enable.
REQ-017 SHALL have port o_mem_wdata  output  XLEN  write data.
REQ-018 SHALL have port o_mem_wstrb  output  XLEN/8  write strobes.
REQ-019 SHALL have port i_mem_rsp_valid  input  1  load read data valid.
REQ-020 SHALL have port i_mem_rsp_data  input  XLEN  raw read word.
REQ-021 SHALL have port o_ld_valid  output  1  one-cycle pulse, load data ready for extraction.
REQ-022 SHALL have port o_ld_addr  output  XLEN  original byte address of completed load.
REQ-023 SHALL have port o_ld_rdata  output  XLEN  registered raw read word.
REQ-024 SHALL have port o_ld_size  output  2  load size; o_ld_unsigned  output  1  extension type.
REQ-025 SHALL have port o_misaligned  output  1  one-cycle pulse, misaligned request rejected.

Function
REQ-026 SHALL implement FSM IDLE, REQ, WAIT, DRAIN; o_req_ready=1 only in IDLE.
REQ-027 SHALL, on i_req_valid&o_req_ready with no misalignment and no i_flush, latch all request fields and enter REQ.
REQ-028 SHALL treat halfword with addr[0]=1 or word with addr[1:0]!=0 as misaligned: no memory request, o_misaligned pulses next cycle, stays IDLE.
REQ-029 SHALL drive o_mem_req_valid=1 only in REQ with latched fields held stable until i_mem_req_ready.
REQ-030 SHALL, in REQ on i_mem_req_ready: store -> IDLE (no response expected); load -> WAIT.
REQ-031 SHALL, in WAIT on i_mem_rsp_valid, register data/addr/size/unsigned to o_ld_* and pulse o_ld_valid the next cycle, then IDLE.
REQ-032 SHALL give load latency: accept cycle N, o_mem_req_valid cycle N+1, response earliest N+2, o_ld_valid N+3.
REQ-033 SHALL, on i_flush in IDLE, ignore a concurrent request; in REQ before acceptance, drop to IDLE (i_flush wins over same-cycle i_mem_req_ready).
REQ-034 SHALL, on i_flush in WAIT without response, enter DRAIN; DRAIN discards next response and returns to IDLE; flush coincident with response discards it, goes IDLE.
REQ-035 SHALL never pulse o_ld_valid for a flushed or store access; o_ld_* data outputs hold value between pulses.

Reset
REQ-036 SHALL on i_rst_n=0 asynchronously force IDLE, o_mem_req_valid=0, o_ld_valid=0, o_misaligned=0, all data/address outputs 0; o_req_ready=1 after release.
REQ-037 SHALL abandon any in-flight access on reset mid-operation; a late response after reset is ignored (IDLE).

Structure
REQ-038 SHALL take the state enum and size encoding (BYTE/HALF/WORD) from the shared CPU package.
REQ-039 SHALL be a single module, no sub-modules; extraction stays in load_unit downstream.

Verification
REQ-040 LW addr 0x104, ready immediate, rsp 0xDEADBEEF -> o_ld_valid at N+3, o_ld_rdata=0xDEADBEEF, o_ld_addr=0x104.
REQ-041 SH addr 0x202, wstrb 0xC, i_mem_req_ready low 3 cycles -> o_mem_addr=0x200 stable 4 cycles, no o_ld_valid, IDLE after accept.
REQ-042 LH addr 0x101 -> o_misaligned one pulse, o_mem_req_valid never asserted.
REQ-043 LB addr 0x103, flush in WAIT, rsp 2 cycles later -> no o_ld_valid, o_req_ready high after response.
REQ-044 LW in WAIT, i_rst_n low 1 cycle then response arrives -> all outputs 0, no o_ld_valid.
